// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops FIFO words and sends them as UART frames (start, data LSB first, [parity], stop).
// Define UART_TX_PARITY_EN to add a parity bit after the data bits (PARITY_ODD selects odd parity).
module fifo_uart_tx #(
  parameter int WIDTH = 8,
  parameter int CLK_DIV = 16,
  parameter int STOP_BITS = 1,
`ifdef UART_TX_PARITY_EN
  parameter bit PARITY_ODD = 1'b0,
`endif
  parameter int CNT_WIDTH = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, PARITY, STOP} state_t;
  localparam int BW = $clog2(WIDTH + 2);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  state_t state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_WIDTH-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic period_end;
  logic [WIDTH-1:0] shnext;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  assign period_end = cnt == LAST;
  assign shnext = shreg >> 1;
  assign rd_en = state == FETCH;
  assign busy = state != IDLE;
  // bit_cnt counts data bits in DATA and stop bits in STOP, so the stop period never needs a wider timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      bit_cnt <= '0;
      tx <= 1'b1;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      cnt <= (state inside {START, DATA, PARITY, STOP} && !period_end) ? cnt + 1'b1 : '0;
      case (state)
        IDLE: if (enable && !empty) state <= FETCH;
        FETCH: state <= WAIT;
        WAIT: begin
          shreg <= rdata;
`ifdef UART_TX_PARITY_EN
          par <= (^rdata) ^ PARITY_ODD;
`endif
          tx <= 1'b0;
          state <= START;
        end
        START: if (period_end) begin
          state <= DATA;
          tx <= shreg[0];
          bit_cnt <= '0;
        end
        DATA: if (period_end) begin
          shreg <= shnext;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx <= par;
`else
            state <= STOP;
            tx <= 1'b1;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx <= shnext[0];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (period_end) begin
          state <= STOP;
          tx <= 1'b1;
        end
`endif
        STOP: if (period_end) begin
          if (bit_cnt == LAST_STOP) begin
            state <= IDLE;
            tx_done <= 1'b1;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a behavioural FIFO read port.
module tb_fifo_uart_tx;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, empty = 1'b1, empty2 = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic [7:0] rdata2 = 8'h55;
  logic rd_en, tx, busy, tx_done, rd_en2, tx2, busy2, tx_done2;
  int errors = 0, checks = 0, rd_cnt = 0, rd_cnt2 = 0, done_cnt = 0, rd_err = 0;
  logic [7:0] q[$];
  logic [10:0] f2;
  int n;

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(8), .CLK_DIV(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .empty(empty), .rdata(rdata),
    .rd_en(rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  fifo_uart_tx #(.WIDTH(8), .CLK_DIV(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .enable(1'b1), .empty(empty2), .rdata(rdata2),
    .rd_en(rd_en2), .tx(tx2), .busy(busy2), .tx_done(tx_done2)
  );

  // FIFO model: data appears the edge after rd_en, empty flag registered
  always @(posedge clk) begin
    if (rd_en) begin
      if (q.size() == 0) rd_err++;
      else rdata <= q.pop_front();
      rd_cnt++;
    end
    empty <= (q.size() == 0);
    if (rd_en2) rd_cnt2++;
    if (tx_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] w, input int drop_at, input int exp_wait);
    logic [9:0] f;
    int k;
    f = {1'b1, w, 1'b0};
    k = 0;
    do begin tick; k++; end while (!rd_en && k < 50);
    chk("rd_en_seen", rd_en, 1);
    if (exp_wait > 0) chk("gap_cycles", k, exp_wait);
    chk("fetch_tx", tx, 1);
    tick;
    chk("wait_tx", tx, 1);
    chk("wait_rd_en", rd_en, 0);
    for (int i = 0; i < 40; i++) begin
      tick;
      if (i == drop_at) enable = 1'b0;
      chk($sformatf("tx_bit_%0h_%0d", w, i), tx, f[i / 4]);
      chk("busy_frame", busy, 1);
    end
    tick;
    chk("tx_done", tx_done, 1);
    chk("idle_busy", busy, 0);
    chk("idle_tx", tx, 1);
  endtask

  initial begin
    enable = 1'b1;
    tick;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_tx2", tx2, 1);
    @(negedge clk) rst = 1'b1;
    repeat (100) tick;
    chk("empty_no_pop", rd_cnt, 0);
    chk("empty_idle", busy, 0);
    // single frame
    @(negedge clk) q.push_back(8'hA5);
    frame(8'hA5, -1, 0);
    tick;
    chk("single_pops", rd_cnt, 1);
    chk("single_done", done_cnt, 1);
    // back-to-back
    @(negedge clk) begin q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h3C); end
    frame(8'h00, -1, 0);
    frame(8'hFF, -1, 1);
    frame(8'h3C, -1, 1);
    repeat (20) tick;
    chk("b2b_pops", rd_cnt, 4);
    chk("b2b_rd_err", rd_err, 0);
    chk("b2b_done", done_cnt, 4);
    chk("b2b_idle", busy, 0);
    // enable dropped mid-DATA
    @(negedge clk) begin q.push_back(8'h12); q.push_back(8'h34); end
    frame(8'h12, 10, 0);
    repeat (20) tick;
    chk("gated_pops", rd_cnt, 5);
    chk("gated_queued", q.size(), 1);
    chk("gated_idle", busy, 0);
    enable = 1'b1;
    frame(8'h34, -1, 1);
    // asynchronous reset in START
    @(negedge clk) q.push_back(8'h99);
    n = 0;
    do begin tick; n++; end while (!rd_en && n < 50);
    chk("rst_case_rd_en", rd_en, 1);
    repeat (4) tick;
    chk("mid_start_tx", tx, 0);
    rst = 1'b0;
    #1;
    chk("async_tx", tx, 1);
    chk("async_busy", busy, 0);
    chk("async_rd_en", rd_en, 0);
    chk("async_tx_done", tx_done, 0);
    @(negedge clk) rst = 1'b1;
    repeat (100) tick;
    chk("post_rst_pops", rd_cnt, 7);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_rd_err", rd_err, 0);
    // two stop bits, CLK_DIV=2
    f2 = {2'b11, 8'h55, 1'b0};
    @(negedge clk) empty2 = 1'b0;
    n = 0;
    do begin tick; n++; end while (!rd_en2 && n < 50);
    chk("u2_rd_en", rd_en2, 1);
    empty2 = 1'b1;
    tick;
    chk("u2_wait_tx", tx2, 1);
    for (int i = 0; i < 22; i++) begin
      tick;
      chk($sformatf("u2_tx_bit_%0d", i), tx2, f2[i / 2]);
      chk("u2_tx_done_low", tx_done2, 0);
    end
    tick;
    chk("u2_tx_done", tx_done2, 1);
    chk("u2_idle", busy2, 0);
    tick;
    chk("u2_pops", rd_cnt2, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
